dmem_responder: RTL and testbench

Data-memory responder for the MIPS core's load/store port: the memory end of the address/write-data/read-data interface the processor drives for `lw/sw/lb/lh/lbu/lhu/sb/sh`. It accepts one request at a time through a valid/ready handshake and models a fixed access latency. It performs byte/halfword lane selection, sign or zero extension, and byte-enabled writes into an internal word array. It answers each request with a one-cycle response pulse, which lets multicycle and stalling cores be exercised against realistic memory timing.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data memory (slave).
interface dmem_responder_if;
    logic        req;
    logic        ready;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        misalign;

    modport master (
        output req, we, size, unsigned_ld, addr, wdata,
        input  ready, rvalid, rdata, misalign
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata,
        output ready, rvalid, rdata, misalign
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one request at a
// time, fixed access latency, byte/halfword lanes with sign/zero extension,
// byte-enabled stores into an internal word array.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            accept;
    logic            enter_resp;

    // request fields captured at accept
    logic            lat_we;
    logic [1:0]      lat_size;
    logic            lat_uns;
    logic [AW+1:0]   lat_addr;
    logic [31:0]     lat_wdata;

    // fields of the transaction being served this cycle
    logic            op_we;
    logic [1:0]      op_size;
    logic            op_uns;
    logic [AW+1:0]   op_addr;
    logic [31:0]     op_wdata;

    logic [AW-1:0]   op_idx;
    logic            op_mis;
    logic [3:0]      op_be;
    logic [31:0]     op_wlanes;
    logic [31:0]     op_word;
    logic [31:0]     op_load;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     rdata_q;
    logic            mis_q;

    logic            unused_addr_hi;

    // address bits above the array size wrap and are deliberately ignored
    assign unused_addr_hi = ^bus.addr[31:AW+2];

    // state and latency counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // next-state logic, accept strobe and the strobe for the commit edge
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CW'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // capture the request fields on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_size  <= '0;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= bus.we;
            lat_size  <= bus.size;
            lat_uns   <= bus.unsigned_ld;
            lat_addr  <= bus.addr[AW+1:0];
            lat_wdata <= bus.wdata;
        end
    end

    // With LATENCY=1 the commit edge is the accept edge itself, so the
    // live bus fields are used while IDLE and the captured ones afterwards.
    always_comb begin
        if (state == IDLE) begin
            op_we    = bus.we;
            op_size  = bus.size;
            op_uns   = bus.unsigned_ld;
            op_addr  = bus.addr[AW+1:0];
            op_wdata = bus.wdata;
        end else begin
            op_we    = lat_we;
            op_size  = lat_size;
            op_uns   = lat_uns;
            op_addr  = lat_addr;
            op_wdata = lat_wdata;
        end
    end

    // alignment check, byte enables and lane-replicated store data
    always_comb begin
        op_idx    = op_addr[AW+1:2];
        op_mis    = 1'b0;
        op_be     = '0;
        op_wlanes = '0;
        case (op_size)
            2'b00: begin
                op_be     = 4'b0001 << op_addr[1:0];
                op_wlanes = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                op_wlanes = {2{op_wdata[15:0]}};
                if (op_addr[0]) begin
                    op_mis = 1'b1;
                end else begin
                    op_be = op_addr[1] ? 4'b1100 : 4'b0011;
                end
            end
            2'b10: begin
                op_wlanes = op_wdata;
                if (op_addr[1:0] != 2'b00) begin
                    op_mis = 1'b1;
                end else begin
                    op_be = 4'b1111;
                end
            end
            default: begin
                op_mis = 1'b1;
            end
        endcase
    end

    // load lane selection and sign/zero extension
    always_comb begin
        op_word = mem[op_idx];
        op_load = '0;
        ld_byte = '0;
        ld_half = '0;
        case (op_addr[1:0])
            2'd0:    ld_byte = op_word[7:0];
            2'd1:    ld_byte = op_word[15:8];
            2'd2:    ld_byte = op_word[23:16];
            default: ld_byte = op_word[31:24];
        endcase
        ld_half = op_addr[1] ? op_word[31:16] : op_word[15:0];
        if (!op_mis) begin
            case (op_size)
                2'b00:   op_load = op_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                2'b01:   op_load = op_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
                2'b10:   op_load = op_word;
                default: op_load = '0;
            endcase
        end
    end

    // byte-enabled store, committed on the edge that enters RESP
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && op_we && !op_mis) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (op_be[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wlanes[8*b +: 8];
                end
            end
        end
    end

    // response data registered on the commit edge, zero at all other times
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= op_we ? '0 : op_load;
            mis_q   <= op_mis;
        end else begin
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.rvalid   = (state == RESP);
    assign bus.rdata    = rdata_q;
    assign bus.misalign = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2/64-word instance and a
// LATENCY=1/16-word instance.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if b0 ();
    dmem_responder_if b1 ();

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one transaction: returns captured response, cycles to rvalid, ready-low cycles
    task automatic txn(input virtual dmem_responder_if v, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic mis, output int lat, output int rlow);
        int n;
        @(negedge clk);
        v.we = w; v.size = sz; v.unsigned_ld = u; v.addr = a; v.wdata = d; v.req = 1'b1;
        n = 0;
        while (v.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 v.req = 1'b0;
        lat = 0; rlow = 0; rd = 'x; mis = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (v.ready === 1'b0) rlow++;
            if (v.rvalid === 1'b1) begin
                rd  = v.rdata;
                mis = v.misalign;
                break;
            end
        end
    endtask

    task automatic acc(input virtual dmem_responder_if v, input string tag, input int explat,
                       input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_mis, input bit chk_rd);
        logic [31:0] rd;
        logic        mis;
        int          lat, rlow;
        txn(v, w, sz, u, a, d, rd, mis, lat, rlow);
        chk({tag, "_lat"}, lat, explat);
        chk({tag, "_rdylow"}, rlow, explat);
        chk({tag, "_mis"}, {31'b0, mis}, {31'b0, exp_mis});
        if (chk_rd) chk({tag, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        logic        rdy [4];
        logic        rv  [4];
        logic [31:0] rdv [4];
        logic [31:0] cap;
        int          pulses;

        b0.req = 1'b0; b0.we = 1'b0; b0.size = 2'b10; b0.unsigned_ld = 1'b0;
        b0.addr = '0; b0.wdata = '0;
        b1.req = 1'b0; b1.we = 1'b0; b1.size = 2'b10; b1.unsigned_ld = 1'b0;
        b1.addr = '0; b1.wdata = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready",    {31'b0, b0.ready},    32'd1);
        chk("rst_rvalid",   {31'b0, b0.rvalid},   32'd0);
        chk("rst_rdata",    b0.rdata,             32'd0);
        chk("rst_misalign", {31'b0, b0.misalign}, 32'd0);

        // LATENCY=1 instance: store, then req held high for back-to-back loads
        acc(b1, "l1_sw", 1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h55AA1234, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        b1.we = 1'b0; b1.size = 2'b10; b1.unsigned_ld = 1'b0; b1.addr = 32'h8; b1.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            rdy[i] = b1.ready;
            rv[i]  = b1.rvalid;
            rdv[i] = b1.rdata;
        end
        b1.req = 1'b0;
        chk("l1_b2b_ready", {28'b0, rdy[0], rdy[1], rdy[2], rdy[3]}, 32'b1010);
        chk("l1_b2b_rvalid", {28'b0, rv[0], rv[1], rv[2], rv[3]}, 32'b0101);
        chk("l1_b2b_rdata1", rdv[1], 32'h55AA1234);
        chk("l1_b2b_rdata3", rdv[3], 32'h55AA1234);
        @(negedge clk);
        chk("l1_nodup_rvalid", {31'b0, b1.rvalid}, 32'd0);
        acc(b1, "l1_wrap", 1, 1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 32'h55AA1234, 1'b0, 1'b1);

        // word round-trip and idle outputs afterwards
        acc(b0, "sw_10", 2, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        acc(b0, "lw_10", 2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        @(negedge clk);
        chk("idle_rdata",  b0.rdata, 32'd0);
        chk("idle_ready",  {31'b0, b0.ready},  32'd1);
        chk("idle_rvalid", {31'b0, b0.rvalid}, 32'd0);

        // byte lanes and extension
        acc(b0, "pre_10", 2, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 1'b0);
        acc(b0, "lb_13",  2, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
        acc(b0, "lbu_13", 2, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 1'b1);
        acc(b0, "lb_12",  2, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        acc(b0, "lh_10",  2, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00007F01, 1'b0, 1'b1);
        acc(b0, "lhu_12", 2, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h000080FF, 1'b0, 1'b1);
        acc(b0, "lw_u_10", 2, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h80FF7F01, 1'b0, 1'b1);

        // partial stores; upper store-data bits must not leak into other lanes
        acc(b0, "sw_20",  2, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b0);
        acc(b0, "sb_21",  2, 1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AA, 32'h0, 1'b0, 1'b0);
        acc(b0, "lw_20a", 2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 1'b1);
        acc(b0, "sh_22",  2, 1'b1, 2'b01, 1'b0, 32'h22, 32'h9876BEEF, 32'h0, 1'b0, 1'b0);
        acc(b0, "lw_20b", 2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 1'b1);

        // misalignment
        acc(b0, "sw_mis22", 2, 1'b1, 2'b10, 1'b0, 32'h22, 32'h0BADF00D, 32'h0, 1'b1, 1'b1);
        acc(b0, "lh_mis21", 2, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1'b1);
        acc(b0, "lw_20c",   2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 1'b1);
        acc(b0, "sz11_20",  2, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1);
        acc(b0, "sz11_st",  2, 1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        acc(b0, "lw_20d",   2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 1'b1);

        // address wrap
        acc(b0, "sw_104", 2, 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        acc(b0, "lw_004", 2, 1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

        // req pulsed during BUSY (as a store) is dropped
        @(negedge clk);
        b0.we = 1'b0; b0.size = 2'b10; b0.unsigned_ld = 1'b0; b0.addr = 32'h4; b0.req = 1'b1;
        @(posedge clk);
        #1 b0.req = 1'b0;
        pulses = 0;
        cap = 'x;
        @(negedge clk);
        b0.we = 1'b1; b0.addr = 32'h4; b0.wdata = 32'h0; b0.req = 1'b1;
        @(posedge clk);
        #1 b0.req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b0.rvalid === 1'b1) begin
                if (pulses == 0) cap = b0.rdata;
                pulses++;
            end
        end
        chk("busy_req_pulses", pulses, 32'd1);
        chk("busy_req_rdata", cap, 32'hCAFEF00D);
        acc(b0, "lw_004b", 2, 1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

        // reset in BUSY abandons the store
        acc(b0, "sw0_30", 2, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        b0.we = 1'b1; b0.size = 2'b10; b0.addr = 32'h30; b0.wdata = 32'h12345678; b0.req = 1'b1;
        @(posedge clk);
        #1 begin
            b0.req = 1'b0;
            reset  = 1'b1;
        end
        pulses = 0;
        @(negedge clk);
        if (b0.rvalid === 1'b1) pulses++;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b0.rvalid === 1'b1) pulses++;
        end
        chk("rstbusy_pulses", pulses, 32'd0);
        chk("rstbusy_ready", {31'b0, b0.ready}, 32'd1);
        acc(b0, "lw_30", 2, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
